// File: rtl/fixed_mac_arbiter.sv
// Round-robin arbiter that lends one fixed_mac to NREQ requesters for a whole vector and returns the tagged result.
// Grant 1 cycle after a request in IDLE, combinational operand forwarding, result 1 cycle after mac_out_valid; res_ready stalls in RESULT.
module fixed_mac_arbiter #(
    parameter int NREQ    = 4,
    parameter int WA      = 12,
    parameter int WB      = 8,
    parameter int WO      = 45,
    parameter int TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ*WA-1:0]      req_a_data,
    input  logic [NREQ-1:0]         req_a_valid,
    input  logic [NREQ-1:0]         req_a_last,
    output logic [NREQ-1:0]         req_a_ready,
    input  logic [NREQ*WB-1:0]      req_b_data,
    input  logic [NREQ-1:0]         req_b_valid,
    input  logic [NREQ-1:0]         req_b_last,
    output logic [NREQ-1:0]         req_b_ready,
    output logic [WA-1:0]           mac_a_data,
    output logic                    mac_a_valid,
    output logic                    mac_a_last,
    input  logic                    mac_a_ready,
    output logic [WB-1:0]           mac_b_data,
    output logic                    mac_b_valid,
    output logic                    mac_b_last,
    input  logic                    mac_b_ready,
    input  logic [WO-1:0]           mac_out_data,
    input  logic                    mac_out_valid,
    output logic                    mac_out_ready,
    output logic [WO-1:0]           res_data,
    output logic [$clog2(NREQ)-1:0] res_id,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic                    timeout_err,
    output logic                    busy
);

    localparam int IDW = $clog2(NREQ);
    localparam int WDW = $clog2(TIMEOUT);
    localparam logic [WDW-1:0] WD_LAST   = WDW'(TIMEOUT - 1);
    localparam logic [IDW-1:0] LAST_INIT = IDW'(NREQ - 1);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_WAIT, S_RESULT} state_t;

    state_t          state_q;
    logic [IDW-1:0]  grant_q, last_grant_q, winner, scan_idx;
    logic            a_done_q, b_done_q, a_done_d, b_done_d;
    logic [WDW-1:0]  wd_q;
    logic [WO-1:0]   res_data_q;
    logic            timeout_q;
    logic [NREQ-1:0] req;
    logic            a_open, b_open;
    logic [WA-1:0]   a_dat [NREQ];
    logic [WB-1:0]   b_dat [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_dat[i] = req_a_data[i*WA +: WA];
        assign b_dat[i] = req_b_data[i*WB +: WB];
    end

    assign req = req_a_valid & req_b_valid;

    // Scan downward from the farthest slot so the nearest requester after last_grant wins.
    always_comb begin
        winner   = last_grant_q;
        scan_idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            scan_idx = IDW'((int'(last_grant_q) + k) % NREQ);
            if (req[scan_idx]) winner = scan_idx;
        end
    end

    assign a_open = (state_q == S_STREAM) && !a_done_q;
    assign b_open = (state_q == S_STREAM) && !b_done_q;

    always_comb begin
        mac_a_data  = a_dat[grant_q];
        mac_b_data  = b_dat[grant_q];
        mac_a_valid = a_open & req_a_valid[grant_q];
        mac_a_last  = a_open & req_a_last[grant_q];
        mac_b_valid = b_open & req_b_valid[grant_q];
        mac_b_last  = b_open & req_b_last[grant_q];
        req_a_ready = '0;
        req_b_ready = '0;
        if (a_open) req_a_ready[grant_q] = mac_a_ready;
        if (b_open) req_b_ready[grant_q] = mac_b_ready;
    end

    assign a_done_d = a_done_q | (mac_a_valid & mac_a_ready & mac_a_last);
    assign b_done_d = b_done_q | (mac_b_valid & mac_b_ready & mac_b_last);

    assign mac_out_ready = (state_q == S_WAIT) & mac_out_valid;
    assign res_valid     = (state_q == S_RESULT);
    assign res_id        = grant_q;
    assign res_data      = res_data_q;
    assign timeout_err   = timeout_q;
    assign busy          = (state_q != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            last_grant_q <= LAST_INIT;
            a_done_q     <= 1'b0;
            b_done_q     <= 1'b0;
            wd_q         <= '0;
            res_data_q   <= '0;
            timeout_q    <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (|req) begin
                        grant_q  <= winner;
                        a_done_q <= 1'b0;
                        b_done_q <= 1'b0;
                        state_q  <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    a_done_q <= a_done_d;
                    b_done_q <= b_done_d;
                    wd_q     <= '0;
                    if (a_done_d && b_done_d) state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (mac_out_valid) begin
                        res_data_q <= mac_out_data;
                        wd_q       <= '0;
                        state_q    <= S_RESULT;
                    end else if (wd_q == WD_LAST) begin
                        // Abort counts as this requester's turn so a dead MAC cannot pin the grant.
                        timeout_q    <= 1'b1;
                        last_grant_q <= grant_q;
                        wd_q         <= '0;
                        state_q      <= S_IDLE;
                    end else begin
                        wd_q <= wd_q + WDW'(1);
                    end
                end
                S_RESULT: begin
                    if (res_ready) begin
                        last_grant_q <= grant_q;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_mac_arbiter.sv
// Directed bench for fixed_mac_arbiter; the bench itself plays the requesters and the MAC.
// Fixed-point formats assumed: A Q4.8, B Q2.6, result 14 fractional bits (1.5 -> 45'h6000).
module tb_fixed_mac_arbiter;
    localparam int NREQ = 4, WA = 12, WB = 8, WO = 45, TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ*WA-1:0] req_a_data;
    logic [NREQ-1:0]   req_a_valid, req_a_last, req_a_ready;
    logic [NREQ*WB-1:0] req_b_data;
    logic [NREQ-1:0]   req_b_valid, req_b_last, req_b_ready;
    logic [WA-1:0]     mac_a_data;
    logic              mac_a_valid, mac_a_last, mac_a_ready;
    logic [WB-1:0]     mac_b_data;
    logic              mac_b_valid, mac_b_last, mac_b_ready;
    logic [WO-1:0]     mac_out_data;
    logic              mac_out_valid, mac_out_ready;
    logic [WO-1:0]     res_data;
    logic [1:0]        res_id;
    logic              res_valid, res_ready, timeout_err, busy;

    int passed = 0;
    int total  = 0;

    fixed_mac_arbiter #(.NREQ(NREQ), .WA(WA), .WB(WB), .WO(WO), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req_a_data(req_a_data), .req_a_valid(req_a_valid), .req_a_last(req_a_last), .req_a_ready(req_a_ready),
        .req_b_data(req_b_data), .req_b_valid(req_b_valid), .req_b_last(req_b_last), .req_b_ready(req_b_ready),
        .mac_a_data(mac_a_data), .mac_a_valid(mac_a_valid), .mac_a_last(mac_a_last), .mac_a_ready(mac_a_ready),
        .mac_b_data(mac_b_data), .mac_b_valid(mac_b_valid), .mac_b_last(mac_b_last), .mac_b_ready(mac_b_ready),
        .mac_out_data(mac_out_data), .mac_out_valid(mac_out_valid), .mac_out_ready(mac_out_ready),
        .res_data(res_data), .res_id(res_id), .res_valid(res_valid), .res_ready(res_ready),
        .timeout_err(timeout_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One single-beat job from an IDLE start with every requester asserting valid+last.
    task automatic job1(input int id);
        step();
        chk("rr_grant", 64'(req_a_ready), 64'd1 << id);
        step();
        mac_out_valid = 1'b1;
        mac_out_data  = WO'(100 + id);
        step();
        mac_out_valid = 1'b0;
        chk("rr_res_id", 64'(res_id), 64'(id));
        chk("rr_res_data", 64'(res_data), 64'(100 + id));
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req_a_data = {NREQ{12'hABC}}; req_b_data = {NREQ{8'h5A}};
        req_a_valid = '0; req_a_last = '0; req_b_valid = '0; req_b_last = '0;
        mac_a_ready = 1'b1; mac_b_ready = 1'b1;
        mac_out_data = '0; mac_out_valid = 1'b0; res_ready = 1'b0;
        step(); step();
        chk("rst_a_ready", 64'(req_a_ready), 64'd0);
        chk("rst_b_ready", 64'(req_b_ready), 64'd0);
        chk("rst_mac_a_valid", 64'(mac_a_valid), 64'd0);
        chk("rst_mac_b_valid", 64'(mac_b_valid), 64'd0);
        chk("rst_mac_a_last", 64'(mac_a_last), 64'd0);
        chk("rst_mac_b_last", 64'(mac_b_last), 64'd0);
        chk("rst_mac_out_ready", 64'(mac_out_ready), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_res_data", 64'(res_data), 64'd0);
        chk("rst_res_id", 64'(res_id), 64'd0);
        chk("rst_timeout", 64'(timeout_err), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        reset = 1'b0;

        // Single job on requester 2: A = {1.0, 2.0}, B = {0.5, 0.5}.
        req_a_data[2*WA +: WA] = 12'h100; req_b_data[2*WB +: WB] = 8'h20;
        req_a_valid[2] = 1'b1; req_b_valid[2] = 1'b1;
        #1;
        chk("s_idle_busy", 64'(busy), 64'd0);
        chk("s_idle_ready", 64'(req_a_ready), 64'd0);
        step();
        chk("s_busy", 64'(busy), 64'd1);
        chk("s_a_valid", 64'(mac_a_valid), 64'd1);
        chk("s_a_data", 64'(mac_a_data), 64'h100);
        chk("s_b_data", 64'(mac_b_data), 64'h20);
        chk("s_a_ready", 64'(req_a_ready), 64'b0100);
        chk("s_b_ready", 64'(req_b_ready), 64'b0100);
        chk("s_a_last0", 64'(mac_a_last), 64'd0);
        req_a_data[2*WA +: WA] = 12'h200; req_a_last[2] = 1'b1; req_b_last[2] = 1'b1;
        #1;
        chk("s_a_last1", 64'(mac_a_last), 64'd1);
        chk("s_b_last1", 64'(mac_b_last), 64'd1);
        chk("s_a_data2", 64'(mac_a_data), 64'h200);
        step();
        req_a_valid = '0; req_b_valid = '0; req_a_last = '0; req_b_last = '0;
        chk("s_wait_a_valid", 64'(mac_a_valid), 64'd0);
        chk("s_wait_ready", 64'(req_a_ready | req_b_ready), 64'd0);
        chk("s_wait_busy", 64'(busy), 64'd1);
        chk("s_wait_out_rdy0", 64'(mac_out_ready), 64'd0);
        mac_out_valid = 1'b1; mac_out_data = 45'h6000;
        #1;
        chk("s_out_rdy", 64'(mac_out_ready), 64'd1);
        step();
        mac_out_valid = 1'b0; mac_out_data = '0;
        chk("s_res_valid", 64'(res_valid), 64'd1);
        chk("s_res_id", 64'(res_id), 64'd2);
        chk("s_res_data", 64'(res_data), 64'h6000);
        chk("s_res_out_rdy", 64'(mac_out_ready), 64'd0);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("s_done_valid", 64'(res_valid), 64'd0);
        chk("s_done_busy", 64'(busy), 64'd0);

        // Round-robin from reset: 0,1,2,3 then 0 again.
        reset = 1'b1; step(); reset = 1'b0;
        req_a_valid = '1; req_b_valid = '1; req_a_last = '1; req_b_last = '1;
        job1(0); job1(1); job1(2); job1(3); job1(0);

        // Skewed lasts on requester 1: A ends at beat 3, B at beat 5.
        req_a_valid = 4'b0010; req_b_valid = 4'b0010; req_a_last = '0; req_b_last = '0;
        step();
        for (int b = 1; b <= 5; b++) begin
            req_a_last[1] = (b == 3);
            req_b_last[1] = (b == 5);
            #1;
            if (b >= 4) begin
                chk("k_a_blocked", 64'(mac_a_valid), 64'd0);
                chk("k_a_rdy_blocked", 64'(req_a_ready), 64'd0);
                chk("k_b_rdy", 64'(req_b_ready), 64'b0010);
            end else begin
                chk("k_a_valid", 64'(mac_a_valid), 64'd1);
                chk("k_a_last", 64'(mac_a_last), 64'(b == 3));
            end
            step();
        end
        req_a_valid = '0; req_b_valid = '0; req_a_last = '0; req_b_last = '0;
        chk("k_wait_b_valid", 64'(mac_b_valid), 64'd0);
        chk("k_wait_busy", 64'(busy), 64'd1);
        mac_out_valid = 1'b1; mac_out_data = 45'h1_2345_6789;
        #1;
        chk("k_wait_out_rdy", 64'(mac_out_ready), 64'd1);
        step();
        mac_out_valid = 1'b0; mac_out_data = 45'h0_0BAD_0BAD;

        // Backpressure in RESULT with requester 3 pending.
        req_a_valid[3] = 1'b1; req_b_valid[3] = 1'b1; req_a_last[3] = 1'b1; req_b_last[3] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            chk("bp_res_valid", 64'(res_valid), 64'd1);
            chk("bp_res_data", 64'(res_data), 64'h1_2345_6789);
            chk("bp_res_id", 64'(res_id), 64'd1);
            chk("bp_no_grant", 64'(req_a_ready | {3'b0, mac_a_valid}), 64'd0);
            step();
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("bp_idle_valid", 64'(res_valid), 64'd0);
        chk("bp_idle_busy", 64'(busy), 64'd0);

        // Watchdog: requester 3 granted, MAC stays silent.
        step();
        chk("wd_grant3", 64'(req_a_ready), 64'b1000);
        step();
        req_a_valid[0] = 1'b1; req_b_valid[0] = 1'b1; req_a_last[0] = 1'b1; req_b_last[0] = 1'b1;
        for (int k = 1; k <= TIMEOUT - 1; k++) begin
            step();
            chk("wd_no_pulse", 64'(timeout_err), 64'd0);
            chk("wd_busy", 64'(busy), 64'd1);
        end
        step();
        chk("wd_pulse", 64'(timeout_err), 64'd1);
        chk("wd_idle", 64'(busy), 64'd0);
        step();
        chk("wd_pulse_end", 64'(timeout_err), 64'd0);
        chk("wd_next_grant", 64'(req_a_ready), 64'b0001);

        // Complete requester 0's job so last_grant moves away from NREQ-1.
        step();
        mac_out_valid = 1'b1; mac_out_data = 45'h77;
        step();
        mac_out_valid = 1'b0;
        chk("j0_res_id", 64'(res_id), 64'd0);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;

        // Reset mid-vector on requester 1.
        req_a_valid = '1; req_b_valid = '1; req_a_last = '0; req_b_last = '0;
        step();
        chk("mr_grant1", 64'(req_a_ready), 64'b0010);
        step();
        chk("mr_streaming", 64'(mac_a_valid), 64'd1);
        reset = 1'b1;
        step();
        chk("mr_a_ready", 64'(req_a_ready), 64'd0);
        chk("mr_b_ready", 64'(req_b_ready), 64'd0);
        chk("mr_valids", 64'({mac_a_valid, mac_b_valid}), 64'd0);
        chk("mr_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        step();
        chk("mr_regrant0", 64'(req_a_ready), 64'b0001);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
